ctrl_pipe_regs: RTL

Parametrised carrier for decoded control words from the Decode stage through the downstream pipeline stages (default E, M, W).
- Each stage has its own stall and flush.
- Stalls propagate backward automatically.
- Bubbles are inserted behind a stalled stage.
- A global flush_all is provided.
- Per-stage valid bits, an in-flight count and a retire pulse are exported.
- Sits between the main decoder and the datapath; replaces hand-instantiated flopenrc/flopenr chains.

---
 rtl/ctrl_pipe_regs_pkg.sv | 30 +++
 rtl/ctrl_pipe_regs_stage.sv | 61 ++++++
 rtl/ctrl_pipe_regs.sv | 91 +++++++++
 3 files changed

// File: rtl/ctrl_pipe_regs_pkg.sv
// Shared constants for the decoded-control pipeline carrier: default sizes,
// named control-word bit positions and the per-stage register operation.
package ctrl_pipe_regs_pkg;

  localparam int CTRL_W_DEFAULT  = 12;
  localparam int NSTAGES_DEFAULT = 3;

  // Bit positions inside one control word, so consumers can slice a stage
  // tap symbolically, e.g. ctrl_taps[i*CTRL_W + CB_REGWRITE].
  localparam int CB_JUMP      = 0;
  localparam int CB_MEMTOREG  = 1;
  localparam int CB_MEMWRITE  = 2;
  localparam int CB_BRANCH    = 3;
  localparam int CB_ALUSRCB   = 4;
  localparam int CB_REGDST    = 5;
  localparam int CB_REGWRITE  = 6;
  localparam int CB_ALUSRCA   = 7;
  localparam int CB_JAL       = 8;
  localparam int CB_JR        = 9;
  localparam int CB_BAL       = 10;
  localparam int CB_HILOWRITE = 11;

  // What a single register stage does on the next clock edge.
  typedef enum logic [1:0] {
    STG_LOAD  = 2'd0,
    STG_HOLD  = 2'd1,
    STG_CLEAR = 2'd2
  } stage_op_e;

endpackage

// File: rtl/ctrl_pipe_regs_stage.sv
// One control-word register stage: clear beats hold, hold beats load.
module ctrl_stage
  import ctrl_pipe_regs_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] d,
  input  logic              d_valid,
  input  logic              hold,
  input  logic              clear,
  output logic [CTRL_W-1:0] q,
  output logic              q_valid
);

  stage_op_e         op;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic              valid_d, valid_q;

  // Resolve the stage operation from clear/hold priority.
  always_comb begin
    op = STG_LOAD;
    if (clear)     op = STG_CLEAR;
    else if (hold) op = STG_HOLD;
  end

  // Next-state for the control word and its valid bit.
  always_comb begin
    // NOTE: defaulting every output to its current value first keeps this block free of inferred latches.
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    case (op)
      STG_CLEAR: begin
        ctrl_d  = '0;
        valid_d = 1'b0;
      end
      STG_LOAD: begin
        ctrl_d  = d;
        valid_d = d_valid;
      end
      default: ;
    endcase
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign q       = ctrl_q;
  assign q_valid = valid_q;

endmodule

// File: rtl/ctrl_pipe_regs.sv
// Carries decoded control words from Decode through NSTAGES register stages
// with per-stage stall/flush, backward stall propagation and bubble insertion.
module ctrl_pipe_regs
  import ctrl_pipe_regs_pkg::*;
#(
  parameter int CTRL_W  = CTRL_W_DEFAULT,
  parameter int NSTAGES = NSTAGES_DEFAULT,
  parameter int CNT_W   = $clog2(NSTAGES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CTRL_W-1:0]         ctrl_in,
  input  logic                      valid_in,
  input  logic [NSTAGES-1:0]        stall,
  input  logic [NSTAGES-1:0]        flush,
  input  logic                      flush_all,
  output logic [NSTAGES*CTRL_W-1:0] ctrl_taps,
  output logic [NSTAGES-1:0]        valid_taps,
  output logic                      stall_up,
  output logic                      retire,
  output logic [CTRL_W-1:0]         ctrl_retire,
  output logic [CNT_W-1:0]          inflight_cnt
);

  if (NSTAGES < 1) begin : g_bad_nstages
    $error("ctrl_pipe_regs: NSTAGES must be at least 1");
  end

  logic [NSTAGES-1:0]             stall_eff;
  logic [NSTAGES-1:0]             stg_clear;
  logic [NSTAGES-1:0][CTRL_W-1:0] stg_d;
  logic [NSTAGES-1:0]             stg_dv;
  logic [NSTAGES-1:0][CTRL_W-1:0] stg_q;
  logic [NSTAGES-1:0]             valid_q;

  // Backward OR chain: a stall in any later stage freezes every earlier one.
  always_comb begin
    stall_eff              = '0;
    stall_eff[NSTAGES-1]   = stall[NSTAGES-1];
    for (int i = NSTAGES - 2; i >= 0; i--) begin
      stall_eff[i] = stall[i] | stall_eff[i+1];
    end
  end

  assign stg_clear = {NSTAGES{flush_all}} | flush;

  // Stage input muxing: Decode feeds stage 0 (invalid words forced to zero);
  // a stage behind a frozen neighbour receives a bubble so nothing duplicates.
  always_comb begin
    stg_d     = '0;
    stg_dv    = '0;
    stg_d[0]  = valid_in ? ctrl_in : '0;
    stg_dv[0] = valid_in;
    for (int i = 1; i < NSTAGES; i++) begin
      if (!stall_eff[i-1]) begin
        stg_d[i]  = stg_q[i-1];
        stg_dv[i] = valid_q[i-1];
      end
    end
  end

  for (genvar g = 0; g < NSTAGES; g++) begin : g_stage
    ctrl_stage #(
      .CTRL_W (CTRL_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .d       (stg_d[g]),
      .d_valid (stg_dv[g]),
      .hold    (stall_eff[g]),
      .clear   (stg_clear[g]),
      .q       (stg_q[g]),
      .q_valid (valid_q[g])
    );
  end

  // Population count of the valid flops.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < NSTAGES; i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(valid_q[i]);
    end
  end

  assign ctrl_taps   = stg_q;
  assign valid_taps  = valid_q;
  assign stall_up    = stall_eff[0];
  assign retire      = valid_q[NSTAGES-1] & ~stall_eff[NSTAGES-1];
  assign ctrl_retire = stg_q[NSTAGES-1];

endmodule
